score_argmax: RTL and testbench

- Downstream consumer of the output-layer neurons in the Morse decoder.
- Takes one 8-bit unsigned neuron score per accepted cycle, serially, in class order.
- After N_CLASSES scores, reports the index and value of the largest score as the decoded symbol, with a one-cycle done pulse.
- Back-to-back frames are supported with no stall cycles.

---
 rtl/decoder_pkg.sv | 19 +
 rtl/score_argmax_if.sv | 30 +++
 rtl/score_argmax_max_cmp.sv | 22 ++
 rtl/score_argmax.sv | 144 ++++++++++++++
 tb/tb_score_argmax.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared Morse decoder constants, phase enum and class-to-ASCII table
package decoder_pkg;

    localparam int N_CLASSES_DEF = 27;
    localparam int SCORE_W       = 8;

    typedef enum logic {
        PH_IDLE,
        PH_ACCUM
    } phase_e;

    // Class order of the output layer: 26 letters, then space.
    localparam logic [7:0] CLASS_ASCII [0:N_CLASSES_DEF-1] = '{
        8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
        8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h50, 8'h51, 8'h52,
        8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5A, 8'h20
    };

endpackage

// File: rtl/score_argmax_if.sv
// rtl/score_argmax_if.sv - score stream in / decoded symbol out; low_conf exists only with ARGMAX_CONF_EN
interface score_argmax_if
    import decoder_pkg::*;
#(
    parameter int W     = SCORE_W,
    parameter int IDX_W = $clog2(N_CLASSES_DEF)
);

    logic [W-1:0]     y;
    logic             y_ready;
    logic             clear;
    logic [IDX_W-1:0] class_idx;
    logic [W-1:0]     max_val;
    logic             done;
    logic             busy;
`ifdef ARGMAX_CONF_EN
    logic             low_conf;

    modport master (output y, y_ready, clear,
                    input  class_idx, max_val, done, busy, low_conf);
    modport slave  (input  y, y_ready, clear,
                    output class_idx, max_val, done, busy, low_conf);
`else
    modport master (output y, y_ready, clear,
                    input  class_idx, max_val, done, busy);
    modport slave  (input  y, y_ready, clear,
                    output class_idx, max_val, done, busy);
`endif

endinterface

// File: rtl/score_argmax_max_cmp.sv
// rtl/score_argmax_max_cmp.sv - combinational strict-greater compare/select of a candidate against the current best
module max_cmp #(
    parameter int W     = 8,
    parameter int IDX_W = 5
) (
    input  logic [W-1:0]     cand_val,
    input  logic [IDX_W-1:0] cand_idx,
    input  logic [W-1:0]     cur_val,
    input  logic [IDX_W-1:0] cur_idx,
    output logic             cand_wins,
    output logic [W-1:0]     sel_val,
    output logic [IDX_W-1:0] sel_idx
);

    // Strictly greater, so on a tie the earlier (current) index is kept.
    always_comb begin
        cand_wins = (cand_val > cur_val);
        sel_val   = cand_wins ? cand_val : cur_val;
        sel_idx   = cand_wins ? cand_idx : cur_idx;
    end

endmodule

// File: rtl/score_argmax.sv
// rtl/score_argmax.sv - serial argmax over N_CLASSES neuron scores; ARGMAX_CONF_EN adds second-max low_conf flag
module score_argmax
    import decoder_pkg::*;
#(
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int W         = SCORE_W,
    parameter int IDX_W     = $clog2(N_CLASSES),
    parameter int MARGIN    = 4
) (
    input  logic               clk,
    input  logic               reset,
    score_argmax_if.slave      bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    logic [IDX_W-1:0] count_q, count_d;
    logic [W-1:0]     run_max_q, run_max_d;
    logic [IDX_W-1:0] run_idx_q, run_idx_d;
    logic [IDX_W-1:0] class_idx_q, class_idx_d;
    logic [W-1:0]     max_val_q, max_val_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    phase_e           phase;
    logic             cand_wins;
    logic [W-1:0]     cmp_val, new_max;
    logic [IDX_W-1:0] cmp_idx, new_idx;

    assign phase = (count_q == '0) ? PH_IDLE : PH_ACCUM;

    max_cmp #(.W(W), .IDX_W(IDX_W)) u_max (
        .cand_val  (bus.y),
        .cand_idx  (count_q),
        .cur_val   (run_max_q),
        .cur_idx   (run_idx_q),
        .cand_wins (cand_wins),
        .sel_val   (cmp_val),
        .sel_idx   (cmp_idx)
    );

    // The first score of a frame always loads, even when it is zero.
    assign new_max = (phase == PH_IDLE) ? bus.y : cmp_val;
    assign new_idx = (phase == PH_IDLE) ? '0    : cmp_idx;

`ifdef ARGMAX_CONF_EN
    logic [W-1:0]     run_second_q, run_second_d;
    logic [W-1:0]     sec_val, new_second;
    logic             low_conf_q, low_conf_d;
    logic             sec_wins_unused;
    logic [IDX_W-1:0] sec_idx_unused;
    logic [W:0]       gap;

    max_cmp #(.W(W), .IDX_W(IDX_W)) u_second (
        .cand_val  (bus.y),
        .cand_idx  (count_q),
        .cur_val   (run_second_q),
        .cur_idx   (count_q),
        .cand_wins (sec_wins_unused),
        .sel_val   (sec_val),
        .sel_idx   (sec_idx_unused)
    );

    // A displaced maximum drops to second; otherwise y competes with the old second.
    assign new_second = (phase == PH_IDLE) ? '0 : (cand_wins ? run_max_q : sec_val);
    assign gap        = {1'b0, new_max} - {1'b0, new_second};
    assign bus.low_conf = low_conf_q;
`else
    localparam int margin_unused = MARGIN;
`endif

    always_comb begin
        count_d     = count_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        class_idx_d = class_idx_q;
        max_val_d   = max_val_q;
        done_d      = 1'b0;
`ifdef ARGMAX_CONF_EN
        run_second_d = run_second_q;
        low_conf_d   = low_conf_q;
`endif
        if (bus.clear) begin
            count_d   = '0;
            run_max_d = '0;
            run_idx_d = '0;
`ifdef ARGMAX_CONF_EN
            run_second_d = '0;
`endif
        end else if (bus.y_ready) begin
            run_max_d = new_max;
            run_idx_d = new_idx;
`ifdef ARGMAX_CONF_EN
            run_second_d = new_second;
`endif
            if (count_q == LAST_IDX) begin
                count_d     = '0;
                class_idx_d = new_idx;
                max_val_d   = new_max;
                done_d      = 1'b1;
`ifdef ARGMAX_CONF_EN
                low_conf_d  = (gap < (W+1)'(MARGIN));
`endif
            end else begin
                count_d = count_q + 1'b1;
            end
        end
        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            class_idx_q <= '0;
            max_val_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ARGMAX_CONF_EN
            run_second_q <= '0;
            low_conf_q   <= 1'b0;
`endif
        end else begin
            count_q     <= count_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            class_idx_q <= class_idx_d;
            max_val_q   <= max_val_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef ARGMAX_CONF_EN
            run_second_q <= run_second_d;
            low_conf_q   <= low_conf_d;
`endif
        end
    end

    assign bus.class_idx = class_idx_q;
    assign bus.max_val   = max_val_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_score_argmax.sv
// tb/tb_score_argmax.sv - scoreboard bench for score_argmax; ARGMAX_CONF_EN enables low_conf frames
module tb_score_argmax;
    import decoder_pkg::*;

    localparam int N      = 27;
    localparam int W      = 8;
    localparam int IDX_W  = $clog2(N);
    localparam int MARGIN = 4;

    typedef struct {
        int unsigned idx;
        int unsigned val;
        bit          low;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_argmax_if #(.W(W), .IDX_W(IDX_W)) bus ();

    score_argmax #(.N_CLASSES(N), .W(W), .IDX_W(IDX_W), .MARGIN(MARGIN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned fr_ramp[N], fr_tie[N], fr_zero[N], fr_b[N], fr_c[N];
    exp_t        last_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference argmax: first strict maximum; second = largest score at any other index.
    function automatic exp_t model(input int unsigned sc[N]);
        exp_t        e;
        int unsigned best = 0;
        int unsigned sec  = 0;
        int          bi   = 0;
        for (int i = 0; i < N; i++)
            if (i == 0 || sc[i] > best) begin
                best = sc[i];
                bi   = i;
            end
        for (int i = 0; i < N; i++)
            if (i != bi && sc[i] > sec) sec = sc[i];
        e.idx = bi;
        e.val = best;
        e.low = ((best - sec) < MARGIN);
        return e;
    endfunction

    task automatic send_scores(input int unsigned sc[N], input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            bus.y       = W'(sc[i]);
            bus.y_ready = 1'b1;
            @(posedge clk); #1;
            if (max_gap > 0) begin
                int g = $urandom_range(max_gap, 0);
                if (g > 0) begin
                    bus.y_ready = 1'b0;
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic send_frame(input int unsigned sc[N], input int max_gap);
        last_exp = model(sc);
        sb.push_back(last_exp);
        send_scores(sc, N, max_gap);
    endtask

    task automatic idle();
        bus.y_ready = 1'b0;
        bus.clear   = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check(tag, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && bus.done !== 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", bus.done, 0);
            end else begin
                e = sb.pop_front();
                check("class_idx", bus.class_idx, e.idx);
                check("max_val", bus.max_val, e.val);
`ifdef ARGMAX_CONF_EN
                check("low_conf", bus.low_conf, e.low);
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            fr_ramp[i] = 5 + 4 * i;
            fr_tie[i]  = (i == 3 || i == 17) ? 200 : 50;
            fr_zero[i] = 0;
            fr_b[i]    = (i == 5) ? 99 : 10 + i;
        end

        bus.y = '0;
        bus.y_ready = 1'b0;
        bus.clear = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_class_idx", bus.class_idx, 0);
        check("rst_max_val", bus.max_val, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
`ifdef ARGMAX_CONF_EN
        check("rst_low_conf", bus.low_conf, 0);
`endif
        reset = 1'b0;

        // Ramp, gapless: done visible right after the edge sampling the 27th score.
        send_frame(fr_ramp, 0);
        check("ramp_done_latency", bus.done, 1);
        check("ramp_busy_after", bus.busy, 0);
        idle();
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 0);
        drain("ramp_drain");

        send_frame(fr_tie, 0);
        idle();
        drain("tie_drain");

        send_scores(fr_zero, 1, 0);
        check("zero_busy_first", bus.busy, 1);
        idle();
        sb.push_back(model(fr_zero));
        send_scores(fr_zero, N - 1, 0);
        idle();
        drain("zero_drain");

        send_frame(fr_ramp, 3);
        idle();
        drain("gaps_drain");

        // Second frame starts in the cycle done is high.
        send_frame(fr_ramp, 0);
        send_frame(fr_b, 0);
        idle();
        drain("b2b_drain");

        // Abort with clear colliding with a score.
        send_scores(fr_tie, 10, 0);
        bus.y = 8'd250;
        bus.clear = 1'b1;
        @(posedge clk); #1;
        check("clear_busy", bus.busy, 0);
        check("clear_done", bus.done, 0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("clear_hold_idx", bus.class_idx, last_exp.idx);
        check("clear_hold_val", bus.max_val, last_exp.val);
        send_frame(fr_tie, 0);
        idle();
        drain("after_clear_drain");

        send_scores(fr_ramp, 5, 0);
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_class_idx", bus.class_idx, 0);
        check("midrst_max_val", bus.max_val, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        reset = 1'b0;
        send_frame(fr_b, 2);
        idle();
        drain("after_rst_drain");

`ifdef ARGMAX_CONF_EN
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++) fr_c[i] = 10;
            fr_c[4] = 100;
            if (t == 0) fr_c[20] = 98;
            if (t == 1) fr_c[20] = 90;
            if (t == 2) fr_c[9]  = 100;
            send_frame(fr_c, 0);
            idle();
            drain("conf_drain");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
